load_store_unit: RTL and testbench

- Memory-stage block between the ALU and the writeback mux.
- For load/store instructions it runs a req/ack transaction with data memory, generates byte enables and lane-replicated store data, and stalls the pipeline while the access is outstanding.
- For loads it registers the aligned, sign/zero-extended result as DDT, which the writeback mux consumes.

---
 rtl/load_store_unit_pkg.sv | 46 ++++
 rtl/load_store_unit_load_align.sv | 28 ++
 rtl/load_store_unit.sv | 153 +++++++++++++++
 tb/tb_load_store_unit.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/load_store_unit_pkg.sv
// Shared decode constants, FSM state type and access-shape helpers for the
// memory-stage load/store unit.
package load_store_unit_pkg;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } lsu_state_e;

  function automatic logic f3_supported(input logic is_store, input logic [2:0] f3);
    if (is_store) return (f3 == F3_SB) || (f3 == F3_SH) || (f3 == F3_SW);
    return (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) ||
           (f3 == F3_LBU) || (f3 == F3_LHU);
  endfunction

  // funct3[1:0] encodes the access size for every supported op
  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] off);
    case (f3[1:0])
      2'b01:   return off[0];
      2'b10:   return off != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] byte_en(input logic [2:0] f3, input logic [1:0] off);
    case (f3[1:0])
      2'b00:   return 4'b0001 << off;
      2'b01:   return 4'b0011 << {off[1], 1'b0};
      default: return 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/load_store_unit_load_align.sv
// Selects the addressed byte/halfword lane of a read word and sign/zero
// extends it according to the load's funct3.
module load_align
  import load_store_unit_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  off_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] result_o
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    byte_v   = rdata_i[8*off_i +: 8];
    half_v   = rdata_i[16*off_i[1] +: 16];
    result_o = rdata_i;
    case (funct3_i)
      F3_LB:   result_o = {{24{byte_v[7]}}, byte_v};
      F3_LH:   result_o = {{16{half_v[15]}}, half_v};
      F3_LBU:  result_o = {24'd0, byte_v};
      F3_LHU:  result_o = {16'd0, half_v};
      default: result_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Memory-stage load/store unit: issues one req/ack data-memory access per
// load/store, stalls the pipe while it is outstanding, registers load data.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [31:0] inst,
  input  logic [31:0] Alu_Out,
  input  logic [31:0] rs2_data,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  output logic [31:0] DDT,
  output logic        stall,
  output logic        done,
  output logic        mem_fault,
  output logic        bus_err
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

  lsu_state_e  state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic        req_q, req_d, we_q, we_d, berr_q, berr_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d, ddt_q, ddt_d;
  logic [3:0]  be_q, be_d;
  logic [1:0]  off_q, off_d;
  logic [2:0]  f3_q, f3_d;

  logic [6:0]  opcode;
  logic [2:0]  f3;
  logic        is_store, memop, fault;
  logic [31:0] load_result, store_data;

  assign opcode   = inst[6:0];
  assign f3       = inst[14:12];
  assign is_store = (opcode == OP_STORE);
  assign memop    = en && ((opcode == OP_LOAD) || is_store);
  assign fault    = !f3_supported(is_store, f3) || misaligned(f3, Alu_Out[1:0]);

  always_comb begin
    case (f3[1:0])
      2'b00:   store_data = {4{rs2_data[7:0]}};
      2'b01:   store_data = {2{rs2_data[15:0]}};
      default: store_data = rs2_data;
    endcase
  end

  load_align u_align (
    .rdata_i  (mem_rdata),
    .off_i    (off_q),
    .funct3_i (f3_q),
    .result_o (load_result)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    off_d   = off_q;
    f3_d    = f3_q;
    ddt_d   = ddt_q;
    berr_d  = berr_q;
    case (state_q)
      S_IDLE: begin
        berr_d = 1'b0;
        if (memop && !fault) begin
          state_d = S_WAIT;
          req_d   = 1'b1;
          we_d    = is_store;
          addr_d  = {Alu_Out[31:2], 2'b00};
          be_d    = byte_en(f3, Alu_Out[1:0]);
          wdata_d = is_store ? store_data : 32'd0;
          off_d   = Alu_Out[1:0];
          f3_d    = f3;
          cnt_d   = '0;
        end
      end
      S_WAIT: begin
        if (mem_ack) begin
          if (!we_q) ddt_d = load_result;
          req_d   = 1'b0;
          state_d = S_DONE;
        end else if ((TIMEOUT != 0) && (cnt_q == CNT_LAST)) begin
          req_d   = 1'b0;
          berr_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      // en is ignored here: it still belongs to the instruction just finished
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= 32'd0;
      be_q    <= 4'd0;
      wdata_q <= 32'd0;
      off_q   <= 2'd0;
      f3_q    <= 3'd0;
      ddt_q   <= 32'd0;
      berr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      off_q   <= off_d;
      f3_q    <= f3_d;
      ddt_q   <= ddt_d;
      berr_q  <= berr_d;
    end
  end

  assign mem_req   = req_q;
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_be    = be_q;
  assign mem_wdata = wdata_q;
  assign DDT       = ddt_q;
  assign stall     = ((state_q == S_IDLE) && memop && !fault) || (state_q == S_WAIT);
  assign mem_fault = (state_q == S_IDLE) && memop && fault;
  assign done      = (state_q == S_DONE);
  assign bus_err   = (state_q == S_DONE) && berr_q;

  logic unused_ok;
  assign unused_ok = ^{inst[31:15], inst[11:7]};

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed plan cases plus random
// loads/stores against a byte-level reference model.
module tb_load_store_unit;

  localparam int TO = 4;
  localparam logic [6:0] OPC_LD = 7'b0000011;
  localparam logic [6:0] OPC_ST = 7'b0100011;

  logic        clk = 1'b0, rst_n = 1'b0, en = 1'b0, mem_ack = 1'b0;
  logic [31:0] inst = '0, Alu_Out = '0, rs2_data = '0, mem_rdata = '0;
  logic        mem_req, mem_we, stall, done, mem_fault, bus_err;
  logic [31:0] mem_addr, mem_wdata, DDT;
  logic [3:0]  mem_be;

  int checks = 0, errors = 0;
  logic [31:0] exp_ddt = '0;

  // observations of the last transaction
  logic        o_fault, o_we, o_berr, o_req_done, o_req_after_fault, o_stall_done;
  logic [31:0] o_addr, o_wdata, o_ddt;
  logic [3:0]  o_be;
  int          o_stall_cnt, o_req_cyc, o_done_cyc;

  load_store_unit #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .inst(inst), .Alu_Out(Alu_Out),
    .rs2_data(rs2_data), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .DDT(DDT), .stall(stall), .done(done),
    .mem_fault(mem_fault), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  // ---------------- reference model ----------------
  function automatic logic m_fault(input logic st, input logic [2:0] f3, input logic [31:0] a);
    logic ok;
    int   nbytes;
    ok     = st ? (f3 <= 3'd2) : (f3 != 3'd3 && f3 != 3'd6 && f3 != 3'd7);
    nbytes = 1 << f3[1:0];
    return !ok || ((int'(a[1:0]) % nbytes) != 0);
  endfunction

  function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [31:0] a);
    int nbytes;
    logic [7:0] m;
    nbytes = 1 << f3[1:0];
    m = 8'(((1 << nbytes) - 1) << a[1:0]);
    return m[3:0];
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] r);
    case (f3[1:0])
      2'd0:    return {24'd0, r[7:0]} * 32'h01010101;
      2'd1:    return {16'd0, r[15:0]} * 32'h00010001;
      default: return r;
    endcase
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
    logic [31:0] v;
    logic signed [7:0]  sb;
    logic signed [15:0] sh;
    v  = d >> (8 * a[1:0]);
    sb = v[7:0];
    sh = v[15:0];
    case (f3)
      3'd0:    return 32'(sb);
      3'd1:    return 32'(sh);
      3'd4:    return {24'd0, v[7:0]};
      3'd5:    return {16'd0, v[15:0]};
      default: return d;
    endcase
  endfunction

  // ---------------- stimulus driver (records, does not judge) ----------------
  task automatic run_txn(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] rs2, input int k, input logic [31:0] rdata);
    logic [31:0] r;
    r = $urandom();
    @(negedge clk);
    inst     = {r[31:15], f3, r[11:7], st ? OPC_ST : OPC_LD};
    Alu_Out  = addr;
    rs2_data = rs2;
    en       = 1'b1;
    mem_ack  = 1'b0;
    o_stall_cnt = 0; o_req_cyc = 0; o_done_cyc = 0;
    o_berr = 1'b0; o_req_done = 1'b1; o_stall_done = 1'b1; o_req_after_fault = 1'b0;
    #1;
    o_fault = mem_fault;
    if (stall) o_stall_cnt++;
    if (o_fault) begin
      @(posedge clk); @(negedge clk);
      o_req_after_fault = mem_req;
      if (stall) o_stall_cnt++;
      o_ddt = DDT;
      en = 1'b0;
      return;
    end
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); @(negedge clk);
      if (done) begin
        o_done_cyc   = c;
        o_berr       = bus_err;
        o_ddt        = DDT;
        o_req_done   = mem_req;
        o_stall_done = stall;
        en = 1'b0;
        break;
      end
      if (mem_req) o_req_cyc++;
      if (c == 1) begin
        o_addr = mem_addr; o_be = mem_be; o_we = mem_we; o_wdata = mem_wdata;
      end
      mem_ack   = (k > 0) && (c == k);
      mem_rdata = mem_ack ? rdata : $urandom();
      #1;
      if (stall) o_stall_cnt++;
    end
    mem_ack = 1'b0;
    en      = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    @(negedge clk);
    checks++;
    if ({mem_req, mem_we, mem_addr, mem_be, mem_wdata, DDT, done, bus_err, stall} !== '0) begin
      errors++;
      $display("FAIL reset_state: req=%b we=%b addr=%h be=%b wd=%h ddt=%h done=%b berr=%b stall=%b, want all 0",
               mem_req, mem_we, mem_addr, mem_be, mem_wdata, DDT, done, bus_err, stall);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_lw;
    run_txn(1'b0, 3'b010, 32'h100, 32'h0, 1, 32'hDEADBEEF);
    exp_ddt = 32'hDEADBEEF;
    checks++;
    if ({o_addr, o_be, o_we} !== {32'h100, 4'b1111, 1'b0}) begin
      errors++; $display("FAIL lw_req: addr=%h be=%b we=%b, want 100 1111 0", o_addr, o_be, o_we);
    end
    checks++;
    if (o_stall_cnt !== 2 || o_done_cyc !== 2 || o_stall_done !== 1'b0) begin
      errors++; $display("FAIL lw_timing: stall_cycles=%0d done_at=T+%0d stall_in_done=%b, want 2 2 0",
                         o_stall_cnt, o_done_cyc, o_stall_done);
    end
    checks++;
    if (o_ddt !== exp_ddt || o_berr !== 1'b0 || o_req_done !== 1'b0) begin
      errors++; $display("FAIL lw_result: ddt=%h berr=%b req=%b, want %h 0 0", o_ddt, o_berr, o_req_done, exp_ddt);
    end
  endtask

  task automatic test_load_ext;
    run_txn(1'b0, 3'b000, 32'h103, 32'h0, 2, 32'h80FFFFFF);
    checks++;
    if (o_be !== 4'b1000 || o_ddt !== 32'hFFFFFF80) begin
      errors++; $display("FAIL lb_ext: be=%b ddt=%h, want 1000 ffffff80", o_be, o_ddt);
    end
    run_txn(1'b0, 3'b100, 32'h103, 32'h0, 1, 32'h80FFFFFF);
    checks++;
    if (o_ddt !== 32'h00000080) begin
      errors++; $display("FAIL lbu_ext: ddt=%h, want 00000080", o_ddt);
    end
    run_txn(1'b0, 3'b101, 32'h102, 32'h0, 3, 32'h80010000);
    exp_ddt = 32'h00008001;
    checks++;
    if (o_be !== 4'b1100 || o_ddt !== exp_ddt || o_done_cyc !== 4) begin
      errors++; $display("FAIL lhu_ext: be=%b ddt=%h done_at=%0d, want 1100 00008001 4", o_be, o_ddt, o_done_cyc);
    end
  endtask

  task automatic test_store;
    run_txn(1'b1, 3'b000, 32'h201, 32'h12345678, 1, 32'hCAFEF00D);
    checks++;
    if ({o_we, o_addr, o_be, o_wdata} !== {1'b1, 32'h200, 4'b0010, 32'h78787878}) begin
      errors++; $display("FAIL sb_req: we=%b addr=%h be=%b wd=%h, want 1 200 0010 78787878", o_we, o_addr, o_be, o_wdata);
    end
    checks++;
    if (o_ddt !== exp_ddt) begin
      errors++; $display("FAIL sb_ddt: ddt=%h, want unchanged %h", o_ddt, exp_ddt);
    end
    run_txn(1'b1, 3'b001, 32'h202, 32'h12345678, 2, 32'hCAFEF00D);
    checks++;
    if ({o_we, o_addr, o_be, o_wdata, o_ddt} !== {1'b1, 32'h200, 4'b1100, 32'h56785678, exp_ddt}) begin
      errors++; $display("FAIL sh_req: we=%b addr=%h be=%b wd=%h ddt=%h, want 1 200 1100 56785678 %h",
                         o_we, o_addr, o_be, o_wdata, o_ddt, exp_ddt);
    end
  endtask

  task automatic test_fault;
    logic [2:0]  f3s [4] = '{3'b010, 3'b001, 3'b011, 3'b100};
    logic        sts [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    logic [31:0] ads [4] = '{32'h102, 32'h101, 32'h100, 32'h100};
    for (int i = 0; i < 4; i++) begin
      run_txn(sts[i], f3s[i], ads[i], 32'hFFFFFFFF, 1, 32'h11111111);
      checks++;
      if (o_fault !== 1'b1 || o_stall_cnt !== 0 || o_req_after_fault !== 1'b0 || o_ddt !== exp_ddt) begin
        errors++; $display("FAIL fault_%0d: fault=%b stall_cycles=%0d req=%b ddt=%h, want 1 0 0 %h",
                           i, o_fault, o_stall_cnt, o_req_after_fault, o_ddt, exp_ddt);
      end
    end
    // non-memory instruction: no fault, no stall, no request
    @(negedge clk);
    inst = 32'h00B50533; Alu_Out = 32'h3; en = 1'b1;
    @(posedge clk); @(negedge clk);
    checks++;
    if (mem_fault !== 1'b0 || stall !== 1'b0 || mem_req !== 1'b0) begin
      errors++; $display("FAIL non_memop: fault=%b stall=%b req=%b, want 0 0 0", mem_fault, stall, mem_req);
    end
    en = 1'b0;
  endtask

  task automatic test_timeout;
    run_txn(1'b0, 3'b010, 32'h300, 32'h0, 0, 32'h0);
    checks++;
    if (o_req_cyc !== TO || o_done_cyc !== TO + 1 || o_req_done !== 1'b0) begin
      errors++; $display("FAIL timeout_req: req_cycles=%0d done_at=%0d req_at_done=%b, want %0d %0d 0",
                         o_req_cyc, o_done_cyc, o_req_done, TO, TO + 1);
    end
    checks++;
    if (o_berr !== 1'b1 || o_ddt !== exp_ddt) begin
      errors++; $display("FAIL timeout_err: berr=%b ddt=%h, want 1 %h", o_berr, o_ddt, exp_ddt);
    end
    for (int i = 0; i < 2; i++) begin
      mem_ack = 1'b1; mem_rdata = $urandom();
      @(posedge clk); @(negedge clk);
      checks++;
      if (done !== 1'b0 || bus_err !== 1'b0 || mem_req !== 1'b0 || DDT !== exp_ddt) begin
        errors++; $display("FAIL late_ack_%0d: done=%b berr=%b req=%b ddt=%h, want 0 0 0 %h",
                           i, done, bus_err, mem_req, DDT, exp_ddt);
      end
    end
    mem_ack = 1'b0;
  endtask

  task automatic test_reset_mid;
    @(negedge clk);
    inst = {17'd0, 3'b010, 5'd0, OPC_LD}; Alu_Out = 32'h400; en = 1'b1;
    @(posedge clk); @(negedge clk);
    @(posedge clk); @(negedge clk);
    checks++;
    if (mem_req !== 1'b1 || stall !== 1'b1) begin
      errors++; $display("FAIL mid_wait: req=%b stall=%b, want 1 1", mem_req, stall);
    end
    en = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++;
    if (mem_req !== 1'b0 || stall !== 1'b0 || DDT !== 32'd0) begin
      errors++; $display("FAIL mid_reset: req=%b stall=%b ddt=%h, want 0 0 0", mem_req, stall, DDT);
    end
    exp_ddt = 32'd0;
    mem_ack = 1'b1; mem_rdata = 32'hA5A5A5A5;
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); @(negedge clk);
    checks++;
    if (done !== 1'b0 || mem_req !== 1'b0 || DDT !== exp_ddt) begin
      errors++; $display("FAIL post_reset_ack: done=%b req=%b ddt=%h, want 0 0 0", done, mem_req, DDT);
    end
    mem_ack = 1'b0;
    run_txn(1'b0, 3'b010, 32'h404, 32'h0, 1, 32'h600DF00D);
    exp_ddt = 32'h600DF00D;
    checks++;
    if (o_done_cyc !== 2 || o_ddt !== exp_ddt || o_addr !== 32'h404) begin
      errors++; $display("FAIL fresh_lw: done_at=%0d ddt=%h addr=%h, want 2 %h 404", o_done_cyc, o_ddt, o_addr, exp_ddt);
    end
  endtask

  task automatic test_random;
    for (int i = 0; i < 40; i++) begin
      logic        st;
      logic [2:0]  f3;
      logic [31:0] a, r2, rd;
      int          k;
      st = 1'($urandom_range(1, 0));
      f3 = 3'($urandom_range(7, 0));
      a  = $urandom();
      if ($urandom_range(3, 0) != 0) a[1:0] = (f3[1:0] == 2'd2) ? 2'd0 : (f3[1:0] == 2'd1 ? {a[1], 1'b0} : a[1:0]);
      r2 = $urandom(); rd = $urandom();
      k  = ($urandom_range(5, 0) == 0) ? 0 : int'($urandom_range(TO, 1));
      run_txn(st, f3, a, r2, k, rd);
      checks++;
      if (m_fault(st, f3, a)) begin
        if (o_fault !== 1'b1 || o_stall_cnt !== 0 || o_req_after_fault !== 1'b0 || o_ddt !== exp_ddt) begin
          errors++; $display("FAIL rnd_fault_%0d: st=%b f3=%0d a=%h fault=%b stall_cycles=%0d req=%b ddt=%h",
                             i, st, f3, a, o_fault, o_stall_cnt, o_req_after_fault, o_ddt);
        end
      end else begin
        if (!st && k > 0) exp_ddt = m_load(f3, a, rd);
        if (o_fault !== 1'b0 || o_addr !== {a[31:2], 2'b00} || o_be !== m_be(f3, a) || o_we !== st ||
            o_wdata !== (st ? m_wdata(f3, r2) : 32'd0)) begin
          errors++; $display("FAIL rnd_req_%0d: st=%b f3=%0d a=%h fault=%b addr=%h be=%b we=%b wd=%h want be=%b wd=%h",
                             i, st, f3, a, o_fault, o_addr, o_be, o_we, o_wdata, m_be(f3, a),
                             st ? m_wdata(f3, r2) : 32'd0);
        end
        checks++;
        if (o_ddt !== exp_ddt || o_berr !== (k == 0) || o_done_cyc !== ((k == 0) ? TO + 1 : k + 1) ||
            o_stall_cnt !== o_done_cyc) begin
          errors++; $display("FAIL rnd_done_%0d: k=%0d ddt=%h berr=%b done_at=%0d stall_cycles=%0d, want ddt=%h",
                             i, k, o_ddt, o_berr, o_done_cyc, o_stall_cnt, exp_ddt);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_lw();
    test_load_ext();
    test_store();
    test_fault();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
